// File: rtl/dmem_wbuf.sv
// Data-memory responder with a posted store buffer in front of slow storage.
// Loads forward from the youngest matching buffered store, else read storage.
module dmem_wbuf #(
    parameter int ADDR_W    = 11,
    parameter int BUF_DEPTH = 4,
    parameter int WR_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         dm_ena,
    input  logic                         dm_r,
    input  logic                         dm_w,
    input  logic [31:0]                  dm_addr,
    input  logic [31:0]                  dm_data_w,
    output logic [31:0]                  dm_data,
    output logic                         stall,
    output logic [$clog2(BUF_DEPTH):0]   wb_count,
    output logic                         wb_empty
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = 1 << ADDR_W;
    localparam int YW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic [31:0]       mem    [NW];
    logic [ADDR_W-1:0] e_idx  [BUF_DEPTH];
    logic [31:0]       e_data [BUF_DEPTH];

    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    state_t            state, state_n;
    logic [YW-1:0]     cyc, cyc_n;
    logic [ADDR_W-1:0] idx;
    logic              full, push, commit, load;
    logic              unused_addr;

    assign idx         = dm_addr[ADDR_W+1:2];
    assign unused_addr = ^{dm_addr[31:ADDR_W+2], dm_addr[1:0]};
    assign full        = (count == CW'(BUF_DEPTH));
    assign load        = dm_ena && dm_r;
    assign push        = ena && dm_ena && dm_w && !full;
    assign stall       = dm_ena && dm_w && full;
    assign wb_count    = count;
    assign wb_empty    = (count == '0);

    // Walk oldest to youngest so the youngest valid match wins.
    always_comb begin
        dm_data = mem[idx];
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (CW'(i) < count && e_idx[rd_ptr + PW'(i)] == idx)
                dm_data = e_data[rd_ptr + PW'(i)];
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0 && !load) begin
                    state_n = BUSY;
                    cyc_n   = '0;
                end
            end
            BUSY: begin
                if (cyc == YW'(WR_CYCLES - 1)) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc + YW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cyc    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (commit)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(commit);
        end
    end

    // Buffer payload and storage carry no reset; pointers qualify them.
    always_ff @(posedge clk) begin
        if (push) begin
            e_idx[wr_ptr]  <= idx;
            e_data[wr_ptr] <= dm_data_w;
        end
        if (commit)
            mem[e_idx[rd_ptr]] <= e_data[rd_ptr];
    end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed plus random checks of dmem_wbuf against a queue-based model
// of the store buffer, drain timing and word storage.
module tb_dmem_wbuf;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;
    localparam int WR     = 2;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, dm_ena, dm_r, dm_w;
    logic [31:0] dm_addr, dm_data_w, dm_data;
    logic        stall;
    logic [2:0]  wb_count;
    logic        wb_empty;

    ent_t        q[$];
    logic [31:0] mem_m[int unsigned];
    int          drain_left;
    int          nvec;
    int          nerr;

    dmem_wbuf #(
        .ADDR_W(ADDR_W),
        .BUF_DEPTH(DEPTH),
        .WR_CYCLES(WR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .dm_ena(dm_ena),
        .dm_r(dm_r),
        .dm_w(dm_w),
        .dm_addr(dm_addr),
        .dm_data_w(dm_data_w),
        .dm_data(dm_data),
        .stall(stall),
        .wb_count(wb_count),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    // One clock: drive, check mid-cycle, then advance the model on the edge.
    task automatic step(input logic e, input logic de, input logic r,
                        input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic exp_st);
        int unsigned ix;
        bit found, pushm, cm;
        logic [31:0] ev;
        ena = e; dm_ena = de; dm_r = r; dm_w = w;
        dm_addr = a; dm_data_w = d;
        ix = widx(a);
        exp_st = de && w && (q.size() == DEPTH);
        @(negedge clk);
        chk("wb_count", 32'(wb_count), 32'(q.size()));
        chk("wb_empty", 32'(wb_empty), 32'(q.size() == 0));
        chk("stall", 32'(stall), 32'(exp_st));
        found = 0;
        ev = '0;
        for (int k = q.size() - 1; k >= 0 && !found; k--) begin
            if (q[k].idx == ix) begin
                found = 1;
                ev = q[k].data;
            end
        end
        if (!found && mem_m.exists(ix)) begin
            found = 1;
            ev = mem_m[ix];
        end
        if (found)
            chk("dm_data", dm_data, ev);
        @(posedge clk);
        pushm = e && de && w && (q.size() != DEPTH);
        cm = 0;
        if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) cm = 1;
        end else if (q.size() > 0 && !(de && r)) begin
            drain_left = WR;
        end
        if (cm) begin
            mem_m[q[0].idx] = q[0].data;
            void'(q.pop_front());
        end
        if (pushm) q.push_back('{ix, d});
        #1;
    endtask

    task automatic idle();
        logic s;
        step(1, 0, 0, 0, 32'h0, 32'h0, s);
    endtask

    task automatic lw(input logic [31:0] a);
        logic s;
        step(1, 1, 1, 0, a, 32'h0, s);
    endtask

    // CPU holds a refused store until the block accepts it.
    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        logic s;
        int g;
        g = 0;
        do begin
            step(1, 1, 0, 1, a, d, s);
            g++;
        end while (s && g < 50);
        if (g >= 50) chk("sw_timeout", 32'(g), 32'(0));
    endtask

    task automatic drain_all();
        int g;
        g = 0;
        while (q.size() > 0 && g < 200) begin
            idle();
            g++;
        end
        idle();
        if (g >= 200) chk("drain_timeout", 32'(q.size()), 32'(0));
    endtask

    initial begin
        logic s;
        nvec = 0; nerr = 0; drain_left = 0;
        rst_n = 1'b0;
        ena = 1'b0; dm_ena = 1'b0; dm_r = 1'b0; dm_w = 1'b0;
        dm_addr = '0; dm_data_w = '0;
        #1;
        chk("rst_count", 32'(wb_count), 32'(0));
        chk("rst_empty", 32'(wb_empty), 32'(1));
        chk("rst_stall", 32'(stall), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // forwarding, then the same word from storage
        sw(32'h10, 32'hDEAD_BEEF);
        lw(32'h10);
        chk("fwd_data", dm_data, 32'hDEAD_BEEF);
        drain_all();
        lw(32'h10);
        chk("mem_data", dm_data, 32'hDEAD_BEEF);

        // youngest duplicate wins
        sw(32'h20, 32'h1);
        sw(32'h20, 32'h2);
        lw(32'h20);
        chk("young_fwd", dm_data, 32'h2);
        drain_all();
        lw(32'h20);
        chk("young_mem", dm_data, 32'h2);

        // fill past capacity; stall is held off by the model-driven retry
        for (int i = 0; i < 8; i++)
            sw(32'(4 * i), 32'(i + 1));
        drain_all();
        for (int i = 0; i < 8; i++) begin
            lw(32'(4 * i));
            chk("full_rd", dm_data, 32'(i + 1));
        end

        // loads keep the drain from starting
        sw(32'h40, 32'h4040);
        for (int i = 0; i < 5; i++) lw(32'h40);
        chk("ld_block", 32'(wb_count), 32'(1));
        for (int i = 0; i < WR + 2; i++) idle();

        // ena low: no push, running drain still commits
        sw(32'h84, 32'h0084);
        idle();
        step(0, 1, 0, 1, 32'h80, 32'h55, s);
        for (int i = 0; i < WR + 2; i++) idle();
        lw(32'h84);
        chk("ena_drain", dm_data, 32'h0084);

        // reset mid-drain discards buffered stores
        sw(32'h100, 32'hA); sw(32'h104, 32'hB); sw(32'h108, 32'hC);
        drain_all();
        ena = 1; dm_ena = 0;
        sw(32'h100, 32'h1A); sw(32'h104, 32'h1B); sw(32'h108, 32'h1C);
        dm_ena = 1'b1; dm_w = 1'b1; dm_r = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(wb_count), 32'(0));
        chk("mid_rst_empty", 32'(wb_empty), 32'(1));
        chk("mid_rst_stall", 32'(stall), 32'(0));
        q.delete();
        drain_left = 0;
        dm_ena = 1'b0; dm_w = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lw(32'h100); chk("rst_old0", dm_data, 32'hA);
        lw(32'h104); chk("rst_old1", dm_data, 32'hB);
        lw(32'h108); chk("rst_old2", dm_data, 32'hC);

        // random traffic over a small window with aliased upper bits
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int op;
            a = ($urandom & 32'hFFFF_E000)
              | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 3);
            step($urandom_range(0, 9) != 0, op != 0, op == 1, op == 2,
                 a, $urandom, s);
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
